// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control-bundle layout,
// immediate formats and the per-opcode control words.
package id_pkg;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I_ALU  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  // Control bundle bit positions; alu_op occupies two bits starting at CTL_ALU_OP_LO.
  localparam int CTL_W          = 13;
  localparam int CTL_ALU_SRC    = 0;
  localparam int CTL_MEM_TO_REG = 1;
  localparam int CTL_REG_WRITE  = 2;
  localparam int CTL_MEM_READ   = 3;
  localparam int CTL_MEM_WRITE  = 4;
  localparam int CTL_BRANCH     = 5;
  localparam int CTL_ALU_OP_LO  = 6;
  localparam int CTL_JAL        = 8;
  localparam int CTL_JALR       = 9;
  localparam int CTL_LUI        = 10;
  localparam int CTL_AUIPC      = 11;
  localparam int CTL_ILLEGAL    = 12;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_NONE
  } imm_fmt_e;

  localparam logic [CTL_W-1:0] B_ONE  = CTL_W'(1);
  localparam logic [CTL_W-1:0] B_SRC  = B_ONE << CTL_ALU_SRC;
  localparam logic [CTL_W-1:0] B_M2R  = B_ONE << CTL_MEM_TO_REG;
  localparam logic [CTL_W-1:0] B_RW   = B_ONE << CTL_REG_WRITE;
  localparam logic [CTL_W-1:0] B_MR   = B_ONE << CTL_MEM_READ;
  localparam logic [CTL_W-1:0] B_MW   = B_ONE << CTL_MEM_WRITE;
  localparam logic [CTL_W-1:0] B_BR   = B_ONE << CTL_BRANCH;
  localparam logic [CTL_W-1:0] B_AOP1 = CTL_W'(2'b01) << CTL_ALU_OP_LO;
  localparam logic [CTL_W-1:0] B_AOP2 = CTL_W'(2'b10) << CTL_ALU_OP_LO;
  localparam logic [CTL_W-1:0] B_AOP3 = CTL_W'(2'b11) << CTL_ALU_OP_LO;

  localparam logic [CTL_W-1:0] CTL_R_TYPE = B_RW | B_AOP2;
  localparam logic [CTL_W-1:0] CTL_I_ALU  = B_SRC | B_RW | B_AOP3;
  localparam logic [CTL_W-1:0] CTL_LOADW  = B_SRC | B_M2R | B_RW | B_MR;
  localparam logic [CTL_W-1:0] CTL_STOREW = B_SRC | B_MW;
  localparam logic [CTL_W-1:0] CTL_BRW    = B_BR | B_AOP1;
  localparam logic [CTL_W-1:0] CTL_JALW   = B_RW | B_BR | (B_ONE << CTL_JAL);
  localparam logic [CTL_W-1:0] CTL_JALRW  = B_SRC | B_RW | B_BR | (B_ONE << CTL_JALR) | B_AOP3;
  localparam logic [CTL_W-1:0] CTL_LUIW   = B_SRC | B_RW | (B_ONE << CTL_LUI);
  localparam logic [CTL_W-1:0] CTL_AUIPCW = B_SRC | B_RW | (B_ONE << CTL_AUIPC);
  localparam logic [CTL_W-1:0] CTL_ILLW   = B_ONE << CTL_ILLEGAL;

endpackage

// File: rtl/id_regfile.sv
// Integer register file: x0 hardwired to zero, async clear, two read ports
// that forward same-cycle write-back data.
module id_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // Bypass so an instruction decoded in the write-back cycle sees the new value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register read, control/immediate decode,
// load-use stall and the ID/EX pipeline register.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 16,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_instr,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [AW-1:0]    ex_rd,
  output logic [AW-1:0]    ex_rs1,
  output logic [AW-1:0]    ex_rs2,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [CTL_W-1:0] ex_ctl,
  output logic [CNT_W-1:0] perf_bubbles
);

  logic [6:0]        opcode;
  logic [AW-1:0]     rd, rs1, rs2;
  logic [XLEN-1:0]   rs1_data, rs2_data, imm;
  logic [CTL_W-1:0]  ctl;
  imm_fmt_e          imm_fmt;
  logic              uses_rs1, uses_rs2;
  logic signed [31:0] imm32;
  logic              hazard, advance;

  assign opcode = if_instr[6:0];
  assign rd     = AW'(if_instr[11:7]);
  assign rs1    = AW'(if_instr[19:15]);
  assign rs2    = AW'(if_instr[24:20]);

  id_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (wb_we),
    .wa    (wb_rd),
    .wd    (wb_data),
    .ra1   (rs1),
    .ra2   (rs2),
    .rd1   (rs1_data),
    .rd2   (rs2_data)
  );

  always_comb begin
    ctl      = CTL_ILLW;
    imm_fmt  = IMM_NONE;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R:      begin ctl = CTL_R_TYPE; uses_rs2 = 1'b1; end
      OP_I_ALU:  begin ctl = CTL_I_ALU;  imm_fmt = IMM_I; end
      OP_LOAD:   begin ctl = CTL_LOADW;  imm_fmt = IMM_I; end
      OP_STORE:  begin ctl = CTL_STOREW; imm_fmt = IMM_S; uses_rs2 = 1'b1; end
      OP_BRANCH: begin ctl = CTL_BRW;    imm_fmt = IMM_B; uses_rs2 = 1'b1; end
      OP_JAL:    begin ctl = CTL_JALW;   imm_fmt = IMM_J; uses_rs1 = 1'b0; end
      OP_JALR:   begin ctl = CTL_JALRW;  imm_fmt = IMM_I; end
      OP_LUI:    begin ctl = CTL_LUIW;   imm_fmt = IMM_U; uses_rs1 = 1'b0; end
      OP_AUIPC:  begin ctl = CTL_AUIPCW; imm_fmt = IMM_U; uses_rs1 = 1'b0; end
      default:   ;
    endcase
  end

  // Immediates are assembled as signed 32-bit, then sign-extended to XLEN.
  always_comb begin
    imm32 = '0;
    case (imm_fmt)
      IMM_I: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
      IMM_S: imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      IMM_B: imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
      IMM_J: imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                      if_instr[20], if_instr[30:21], 1'b0};
      IMM_U: imm32 = {if_instr[31:12], 12'b0};
      default: imm32 = '0;
    endcase
  end
  assign imm = XLEN'(imm32);

  // Handshake: IF->ID transfers when if_valid & if_ready; ID->EX transfers when
  // ex_valid & ex_ready. The entry advances if EX takes it or the slot is empty;
  // a load-use hazard holds IF for one bubble, and flush always drains IF.
  assign hazard = if_valid & ex_valid & ex_ctl[CTL_MEM_READ] & (ex_rd != '0) &
                  ((uses_rs1 & (ex_rd == rs1)) | (uses_rs2 & (ex_rd == rs2)));
  assign advance  = ex_ready | ~ex_valid;
  assign if_ready = flush | (advance & ~hazard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_funct3    <= '0;
      ex_funct7    <= '0;
      ex_ctl       <= '0;
      perf_bubbles <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctl   <= '0;
    end else if (advance) begin
      if (hazard) begin
        ex_valid <= 1'b0;
        ex_ctl   <= '0;
        if (perf_bubbles != '1) perf_bubbles <= perf_bubbles + 1'b1;
      end else begin
        ex_valid    <= if_valid;
        ex_ctl      <= if_valid ? ctl : '0;
        ex_pc       <= if_pc;
        ex_rs1_data <= rs1_data;
        ex_rs2_data <= rs2_data;
        ex_imm      <= imm;
        ex_rd       <= rd;
        ex_rs1      <= rs1;
        ex_rs2      <= rs2;
        ex_funct3   <= if_instr[14:12];
        ex_funct7   <= if_instr[31:25];
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe.
module tb_id_stage_pipe;

  logic        clk, reset;
  logic        if_valid, if_ready, flush, wb_we, ex_ready, ex_valid;
  logic [31:0] if_pc, if_instr, wb_data;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  wb_rd, ex_rd, ex_rs1, ex_rs2;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [12:0] ex_ctl;
  logic [15:0] perf_bubbles;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // Hand-derived control words (bit 0 alu_src ... bit 12 illegal).
  localparam logic [12:0] E_R     = 13'h084;
  localparam logic [12:0] E_IALU  = 13'h0C5;
  localparam logic [12:0] E_LOAD  = 13'h00F;
  localparam logic [12:0] E_STORE = 13'h011;
  localparam logic [12:0] E_BR    = 13'h060;
  localparam logic [12:0] E_JAL   = 13'h124;
  localparam logic [12:0] E_LUI   = 13'h405;
  localparam logic [12:0] E_ILL   = 13'h1000;

  id_stage_pipe dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .flush(flush), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_ctl(ex_ctl),
    .perf_bubbles(perf_bubbles)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    if_valid = v;
    if_pc    = pc;
    if_instr = instr;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, op};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
    #3;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ex_valid); end
    checks++; if (ex_ctl !== 13'h0) begin errors++; $display("FAIL reset_ctl: got %0h want 0", ex_ctl); end
    checks++; if (perf_bubbles !== 16'h0) begin errors++; $display("FAIL reset_perf: got %0d want 0", perf_bubbles); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %0b want 1", if_ready); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h100, enc_i(7'h03, 5'd5, 5'd1, 12'd0));   // lw x5,0(x1)
    step();
    checks++; if (ex_ctl !== E_LOAD || ex_valid !== 1'b1) begin errors++; $display("FAIL lu_load: got ctl=%0h v=%0b want %0h 1", ex_ctl, ex_valid, E_LOAD); end
    drive(1'b1, 32'h104, enc_r(5'd6, 5'd5, 5'd2));           // add x6,x5,x2
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got if_ready=%0b want 0", if_ready); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_ctl !== 13'h0) begin errors++; $display("FAIL lu_bubble: got v=%0b ctl=%0h want 0 0", ex_valid, ex_ctl); end
    checks++; if (perf_bubbles !== 16'd1) begin errors++; $display("FAIL lu_perf: got %0d want 1", perf_bubbles); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got if_ready=%0b want 1", if_ready); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 32'h104 || ex_ctl !== E_R) begin
      errors++; $display("FAIL lu_add: got v=%0b rd=%0d pc=%0h ctl=%0h want 1 6 104 %0h", ex_valid, ex_rd, ex_pc, ex_ctl, E_R); end
    checks++; if (perf_bubbles !== 16'd1) begin errors++; $display("FAIL lu_perf_after: got %0d want 1", perf_bubbles); end
  endtask

  task automatic test_x0_filter();
    drive(1'b1, 32'h200, enc_i(7'h03, 5'd0, 5'd1, 12'd0));   // lw x0,0(x1)
    step();
    drive(1'b1, 32'h204, enc_r(5'd6, 5'd0, 5'd0));           // add x6,x0,x0
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL x0_nostall: got if_ready=%0b want 1", if_ready); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204) begin errors++; $display("FAIL x0_pass: got v=%0b pc=%0h want 1 204", ex_valid, ex_pc); end
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
    drive(1'b1, 32'h208, enc_i(7'h13, 5'd8, 5'd0, 12'd0));   // addi x8,x0,0
    step();
    checks++; if (ex_rs1_data !== 32'h0) begin errors++; $display("FAIL x0_bypass: got %0h want 0", ex_rs1_data); end
    wb_we = 0;
    drive(1'b1, 32'h20C, enc_r(5'd9, 5'd0, 5'd0));
    step();
    checks++; if (ex_rs1_data !== 32'h0 || ex_rs2_data !== 32'h0) begin errors++; $display("FAIL x0_stored: got %0h %0h want 0 0", ex_rs1_data, ex_rs2_data); end
  endtask

  task automatic test_bypass();
    wb_we = 1; wb_rd = 5'd7; wb_data = 32'h1234;
    drive(1'b1, 32'h300, enc_i(7'h13, 5'd8, 5'd7, 12'd1));   // addi x8,x7,1
    step();
    wb_we = 0;
    checks++; if (ex_rs1_data !== 32'h1234) begin errors++; $display("FAIL byp_rs1: got %0h want 1234", ex_rs1_data); end
    checks++; if (ex_imm !== 32'h1 || ex_ctl !== E_IALU) begin errors++; $display("FAIL byp_imm_ctl: got %0h %0h want 1 %0h", ex_imm, ex_ctl, E_IALU); end
    drive(1'b1, 32'h304, enc_r(5'd9, 5'd7, 5'd7));
    step();
    checks++; if (ex_rs1_data !== 32'h1234 || ex_rs2_data !== 32'h1234) begin errors++; $display("FAIL byp_stored: got %0h %0h want 1234 1234", ex_rs1_data, ex_rs2_data); end
  endtask

  task automatic test_immediates();
    drive(1'b1, 32'h400, 32'hABCDE1B7);                      // lui x3,0xABCDE
    step();
    checks++; if (ex_imm !== 32'hABCDE000 || ex_ctl !== E_LUI || ex_rd !== 5'd3) begin errors++; $display("FAIL imm_lui: got %0h %0h %0d want ABCDE000 %0h 3", ex_imm, ex_ctl, ex_rd, E_LUI); end
    drive(1'b1, 32'h404, 32'hFE208EE3);                      // beq x1,x2,-4
    step();
    checks++; if (ex_imm !== 32'hFFFFFFFC || ex_ctl !== E_BR) begin errors++; $display("FAIL imm_beq: got %0h %0h want FFFFFFFC %0h", ex_imm, ex_ctl, E_BR); end
    drive(1'b1, 32'h408, 32'h001000EF);                      // jal x1,+2048
    step();
    checks++; if (ex_imm !== 32'h00000800 || ex_ctl !== E_JAL) begin errors++; $display("FAIL imm_jal: got %0h %0h want 800 %0h", ex_imm, ex_ctl, E_JAL); end
    drive(1'b1, 32'h40C, 32'hFE20AC23);                      // sw x2,-8(x1)
    step();
    checks++; if (ex_imm !== 32'hFFFFFFF8 || ex_ctl !== E_STORE) begin errors++; $display("FAIL imm_sw: got %0h %0h want FFFFFFF8 %0h", ex_imm, ex_ctl, E_STORE); end
    drive(1'b1, 32'h410, 32'h40208033);                      // sub x0,x1,x2
    step();
    checks++; if (ex_imm !== 32'h0 || ex_funct7 !== 7'h20 || ex_funct3 !== 3'h0) begin errors++; $display("FAIL imm_r: got %0h f7=%0h f3=%0h want 0 20 0", ex_imm, ex_funct7, ex_funct3); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), enc_i(7'h13, 5'd10, 5'd11, 12'(i)));
      exp_q.push_back(32'h500 + 32'(4 * i));
      #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %0b want 1", i, if_ready); end
      step();
      checks++; if (ex_valid !== 1'b1 || ex_pc !== exp_q[0]) begin errors++; $display("FAIL b2b_pc%0d: got v=%0b pc=%0h want 1 %0h", i, ex_valid, ex_pc, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_backpressure_flush();
    drive(1'b1, 32'h600, enc_i(7'h13, 5'd12, 5'd0, 12'd5));
    step();
    ex_ready = 0;
    drive(1'b1, 32'h604, enc_r(5'd13, 5'd1, 5'd2));
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %0b want 0", i, if_ready); end
      step();
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h600 || ex_imm !== 32'd5 || ex_rd !== 5'd12 || ex_ctl !== E_IALU) begin
        errors++; $display("FAIL bp_hold%0d: got v=%0b pc=%0h imm=%0h rd=%0d ctl=%0h", i, ex_valid, ex_pc, ex_imm, ex_rd, ex_ctl); end
    end
    flush = 1;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fl_ready: got %0b want 1", if_ready); end
    step();
    flush = 0;
    checks++; if (ex_valid !== 1'b0 || ex_ctl !== 13'h0) begin errors++; $display("FAIL fl_kill: got v=%0b ctl=%0h want 0 0", ex_valid, ex_ctl); end
    drive(1'b0, 32'h0, 32'h0);
    ex_ready = 1;
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped: got v=%0b want 0", ex_valid); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h700, 32'h0000007F);
    step();
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (ex_valid !== 1'b1 || ex_ctl !== E_ILL || ex_imm !== 32'h0) begin errors++; $display("FAIL illegal: got v=%0b ctl=%0h imm=%0h want 1 %0h 0", ex_valid, ex_ctl, ex_imm, E_ILL); end
  endtask

  task automatic test_async_reset();
    #1;
    reset = 1;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_ctl !== 13'h0 || perf_bubbles !== 16'h0) begin
      errors++; $display("FAIL async_reset: got v=%0b ctl=%0h perf=%0d want 0 0 0", ex_valid, ex_ctl, perf_bubbles); end
    #1;
    reset = 0;
    drive(1'b1, 32'h800, enc_r(5'd9, 5'd7, 5'd7));
    step();
    checks++; if (ex_rs1_data !== 32'h0 || ex_rs2_data !== 32'h0 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL async_regs: got %0h %0h v=%0b want 0 0 1", ex_rs1_data, ex_rs2_data, ex_valid); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_filter();
    test_bypass();
    test_immediates();
    test_back_to_back();
    test_backpressure_flush();
    test_illegal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
